// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, rcon constants, S-box table and
// word/byte slicing helpers. Used by the key schedule, the cipher round
// and the SubBytes stage.
package aes_pkg;

  localparam int          AES_NR    = 10;
  localparam logic [7:0]  RCON_INIT = 8'h01;
  localparam logic [7:0]  RCON_POLY = 8'h1b;

  typedef enum logic {
    KE_IDLE,
    KE_RUN
  } ke_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Word i of a 128-bit block; word 0 is the most significant.
  function automatic logic [31:0] key_word(input logic [127:0] blk, input int unsigned i);
    return blk[127 - 32*i -: 32];
  endfunction

  // Byte i of a 32-bit word; byte 0 is the most significant.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input int unsigned i);
    return w[31 - 8*i -: 8];
  endfunction

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box, purely combinational table lookup.
//   a : input byte
//   s : substituted byte
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  assign s = SBOX[a];

endmodule

// File: rtl/sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
// Combinational; shared by the AES-128 and AES-256 key schedules.
//   w : input word
//   s : substituted word, byte order preserved
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] w,
  output logic [31:0] s
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox u_sbox (
      .a (word_byte(w, g)),
      .s (s[31 - 8*g -: 8])
    );
  end

endmodule

// File: rtl/key_expand.sv
// AES-128 key schedule. Loads a cipher key on start and streams round keys
// 0..10, one per accepted handshake, to the round datapath.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin an expansion (honoured only when idle)
//   key_in     : cipher key, key_in[127:120] is byte 0
//   busy       : expansion in progress
//   rk_valid   : round_key / rk_idx hold a valid round key
//   rk_ready   : consumer accepts the presented key
//   rk_idx     : round number of round_key
//   round_key  : {w[4i], w[4i+1], w[4i+2], w[4i+3]}
//   done       : last round key (rk_idx == 10) is presented
module key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_idx,
  output logic [127:0] round_key,
  output logic         done
);

  localparam logic [3:0] LAST_IDX = 4'(AES_NR);

  ke_state_t   state;
  logic [7:0]  rcon;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sw, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_word(round_key, 0);
  assign w1 = key_word(round_key, 1);
  assign w2 = key_word(round_key, 2);
  assign w3 = key_word(round_key, 3);

  assign rot = {w3[23:0], w3[31:24]};

  sub_word u_sub_word (
    .w (rot),
    .s (sw)
  );

  // Critical path: round_key[31:0] -> S-box -> four-deep XOR chain.
  always_comb begin
    t  = sw ^ {rcon, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= KE_IDLE;
      rk_valid  <= 1'b0;
      rk_idx    <= '0;
      round_key <= '0;
      rcon      <= RCON_INIT;
    end else begin
      case (state)
        KE_IDLE: begin
          if (start) begin
            state     <= KE_RUN;
            round_key <= key_in;
            rk_idx    <= '0;
            rcon      <= RCON_INIT;
            rk_valid  <= 1'b1;
          end
        end
        KE_RUN: begin
          if (rk_ready) begin
            if (rk_idx == LAST_IDX) begin
              state    <= KE_IDLE;
              rk_valid <= 1'b0;
            end else begin
              round_key <= {n0, n1, n2, n3};
              rk_idx    <= rk_idx + 4'd1;
              rcon      <= xtime(rcon);
            end
          end
        end
        default: state <= KE_IDLE;
      endcase
    end
  end

  assign busy = (state == KE_RUN);
  assign done = rk_valid & (rk_idx == LAST_IDX);

endmodule

// File: tb/tb_key_expand.sv
module tb_key_expand;

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1     = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] KEY_C1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_R1    = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic [127:0] key_in;
  logic         busy, rk_valid, done;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;

  always #5 clk = ~clk;

  key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_idx    (rk_idx),
    .round_key (round_key),
    .done      (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // S-box derived algebraically: multiplicative inverse then affine map.
  logic [7:0] sb_tab [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook word-array key expansion; returns round key k.
  function automatic logic [127:0] model_rk(input logic [127:0] key, input int k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]], sb_tab[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endfunction

  // Behavioural model of the handshake-level behaviour.
  logic         m_active = 1'b0;
  logic [3:0]   m_idx    = '0;
  logic [127:0] m_key    = '0;
  logic [127:0] m_rk     = '0;
  bit           chk_en   = 1'b0;
  int           acc [$];

  always @(posedge clk) begin
    if (!rst && rk_valid && rk_ready) acc.push_back(int'(rk_idx));
    if (rst) begin
      m_active = 1'b0;
      m_idx    = '0;
      m_rk     = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_idx    = '0;
        m_key    = key_in;
        m_rk     = key_in;
      end
    end else if (rk_ready) begin
      if (m_idx == 4'd10) m_active = 1'b0;
      else begin
        m_idx = m_idx + 4'd1;
        m_rk  = model_rk(m_key, int'(m_idx));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",      {127'h0, busy},     {127'h0, m_active});
      check("rk_valid",  {127'h0, rk_valid}, {127'h0, m_active});
      check("done",      {127'h0, done},     {127'h0, m_active && m_idx == 4'd10});
      check("rk_idx",    {124'h0, rk_idx},   {124'h0, m_idx});
      check("round_key", round_key,          m_rk);
    end
  end

  task automatic kick(input logic [127:0] k);
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    if (busy) timeout(name);
  endtask

  task automatic expand_check(input string name, input logic [127:0] k,
                              input logic [127:0] r1, input logic [127:0] r10);
    int nvalid = 0;
    rk_ready = 1'b1;
    kick(k);
    for (int i = 0; i < 16; i++) begin
      if (rk_valid) begin
        nvalid++;
        if (rk_idx == 4'd0) check({name, "_r0"}, round_key, k);
        if (rk_idx == 4'd1) check({name, "_r1"}, round_key, r1);
        if (rk_idx == 4'd10) begin
          check({name, "_r10"}, round_key, r10);
          check({name, "_done"}, {127'h0, done}, 128'h1);
        end
      end
      @(negedge clk);
    end
    check({name, "_nvalid"}, 128'(nvalid), 128'd11);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    build_sbox();
    check("sbox_00", {120'h0, sb_tab[0]},   128'h63);
    check("sbox_53", {120'h0, sb_tab[8'h53]}, 128'hed);
    check("model_a1_r1",  model_rk(KEY_A1, 1),  A1_R1);
    check("model_a1_r10", model_rk(KEY_A1, 10), A1_R10);
    check("model_z_r1",   model_rk('0, 1),      Z_R1);
    check("model_z_r10",  model_rk('0, 10),     Z_R10);
    check("model_c1_r1",  model_rk(KEY_C1, 1),  C1_R1);

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_valid", {127'h0, rk_valid}, 128'h0);
    check("rst_busy",  {127'h0, busy},     128'h0);
    check("rst_done",  {127'h0, done},     128'h0);
    check("rst_idx",   {124'h0, rk_idx},   128'h0);
    check("rst_key",   round_key,          128'h0);
    rst = 1'b0;

    expand_check("a1", KEY_A1, A1_R1, A1_R10);
    expand_check("zero", '0, Z_R1, Z_R10);

    // Random backpressure.
    rk_ready = 1'b0;
    acc.delete();
    kick(KEY_A1);
    for (int i = 0; i < 300 && busy; i++) begin
      rk_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    if (busy) timeout("bp_idle");
    check("bp_count", 128'(acc.size()), 128'd11);
    for (int i = 0; i < acc.size(); i++) check("bp_order", 128'(acc[i]), 128'(i));

    // Start during RUN with a different key is ignored.
    rk_ready = 1'b1;
    kick(KEY_A1);
    for (int i = 0; i < 3; i++) begin
      key_in = ~KEY_A1;
      start  = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 20 && !(rk_valid && rk_idx == 4'd10); i++) @(negedge clk);
    check("sir_r10", round_key, A1_R10);
    wait_idle("sir_idle", 20);

    // Reset mid-expansion, then a fresh key.
    kick(KEY_A1);
    for (int i = 0; i < 20 && rk_idx != 4'd5; i++) @(negedge clk);
    check("rst5_idx", {124'h0, rk_idx}, 128'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst5_valid", {127'h0, rk_valid}, 128'h0);
    check("rst5_busy",  {127'h0, busy},     128'h0);
    check("rst5_key",   round_key,          128'h0);
    kick(KEY_C1);
    check("c1_r0", round_key, KEY_C1);
    @(negedge clk);
    check("c1_r1", round_key, C1_R1);
    wait_idle("c1_idle", 20);

    // Back-to-back with start held high.
    key_in = KEY_A1;
    start  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    check("b2b_done", {127'h0, done}, 128'h1);
    @(negedge clk);
    check("b2b_gap", {127'h0, rk_valid}, 128'h0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_valid", {127'h0, rk_valid}, 128'h1);
    check("b2b_idx",   {124'h0, rk_idx},   128'h0);
    check("b2b_r0",    round_key,          KEY_A1);
    @(negedge clk);
    check("b2b_r1",    round_key,          A1_R1);
    wait_idle("b2b_idle", 20);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_expand.md
# key_expand

AES-128 key schedule generator; the stage directly downstream of the `sbox` S-box and its only consumer in the key path. It accepts a 128-bit cipher key and streams the 11 round keys (round 0 through 10), one per cycle, to the round datapath over a valid/ready handshake. SubWord is computed by four `sbox` instances on the rotated last word of the current round key.

## Interface
Parameters: none. AES-128 only; key length is fixed.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request a new expansion; sampled only in IDLE.
- `key_in`  input  128  cipher key. `key_in[127:120]` is key byte 0. `w0 = key_in[127:96]`.
- `busy`  output  1  high in RUN.
- `rk_valid`  output  1  `round_key` and `rk_idx` hold a valid round key.
- `rk_ready`  input  1  consumer accepts the current round key when `rk_valid & rk_ready`.
- `rk_idx`  output  4  round number of `round_key`, 0..10.
- `round_key`  output  128  round key, `{w[4i], w[4i+1], w[4i+2], w[4i+3]}`.
- `done`  output  1  high while `rk_idx == 10` is presented; the last key.

## Operation
- State machine has two states, IDLE and RUN.
- **IDLE → RUN**: when `start` is high. Load `round_key <= key_in`, `rk_idx <= 0`, `rcon <= 8'h01`, `rk_valid <= 1`.
- **RUN, key accepted with `rk_idx < 10`**:
  - `t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}`.
  - `RotWord(a,b,c,d) = (b,c,d,a)`.
  - Next key: `w0' = w0^t`, `w1' = w1^w0'`, `w2' = w2^w1'`, `w3' = w3^w2'`.
  - `rk_idx` increments by 1.
  - `rcon <= xtime(rcon)`: `{rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00)`.
  - The resulting sequence is 01,02,04,08,10,20,40,80,1b,36.
- **RUN, key accepted with `rk_idx == 10`**: go to IDLE, `rk_valid <= 0`, `busy <= 0`. `round_key` and `rk_idx` keep their last values.
- **RUN, `rk_valid & !rk_ready`**: stall. `round_key`, `rk_idx`, `rcon` and state hold. `key_in` is ignored.
- `start` in RUN is ignored; it neither restarts nor queues a request.
- `start` in the same cycle that round 10 is accepted is ignored. A new expansion needs `start` while in IDLE.
- `key_in` is sampled only on the IDLE→RUN edge. Later changes have no effect.
- SubWord is purely combinational through four `sbox` instances, so it is fully evaluated within the same cycle.

## Timing
- Reset values: state IDLE, `busy=0`, `rk_valid=0`, `done=0`, `rk_idx=0`, `round_key=128'h0`, `rcon=8'h01`.
- `rst` mid-expansion returns to IDLE with the reset values on the next edge. No partial key remains visible.
- `rst` has priority over `start` and over `rk_ready`.
- Latency: `start` sampled at edge N → round 0 valid after edge N.
- With `rk_ready` held high: round k is valid in cycle N+1+k, and `done` is asserted in cycle N+11 together with round 10. That is 11 cycles of `rk_valid`, back to back.
- After round 10 is accepted at edge M: `rk_valid=0` and `busy=0` from edge M onward. The earliest new `start` is sampled at edge M+1.
- `done = rk_valid & (rk_idx == 10)`, driven from registers; no combinational path from inputs.
- `rk_valid`, `round_key` and `rk_idx` are registered.
- The combinational path from `round_key[31:0]` through `sbox` and the XOR chain ends at the `round_key` register. It is the critical path.

## Structure
- Shared package/header `aes_pkg`: `AES_NR = 10`, `RCON_INIT = 8'h01`, `RCON_POLY = 8'h1b`, word/byte slice macros. `aes_pkg` is reused by the cipher round and the SubBytes stage.
- `key_expand` contains:
  - four `sbox` instances for SubWord;
  - the `rcon` register;
  - the FSM;
  - the round-key register.
- One natural sub-module: `sub_word` (32-bit, four `sbox`, combinational). It is also reused by an AES-256 variant later.

## Test plan
- **FIPS-197 A.1**: key `2b7e151628aed2a6abf7158809cf4f3c`, `rk_ready=1` → round 0 = the key; round 1 `a0fafe1788542cb123a339392a6c7605`; round 10 `d014f9a8c9ee2589e13f0cc8b6630ca6` with `done=1`; exactly 11 valid cycles.
- **All-zero key** → round 1 `62636363626363636263636362636363`; round 10 `b4ef5bcb3e92e21123e951cf6f8f188e`.
- **Backpressure**: A.1 key, `rk_ready` random 50% → the same 11 keys in order; outputs stable while stalled; no key skipped or duplicated.
- **`start` during RUN** with a different `key_in` → ignored; the A.1 sequence is unchanged.
- **`rst` at round 5** → next cycle `rk_valid=0`, `busy=0`, `round_key=0`. A fresh `start` then yields a correct round 0/1 from the new key, including `rcon` restarting at 01.
- **Back-to-back expansions** → `start` held high continuously: the second expansion begins one cycle after round 10 is accepted, with correct values.
